// File: rtl/clk_div_trans_mon.sv
// clk_div_trans_mon: divides the serial bit clock by 10/20/40 and counts divided-clock toggles in a host-accessible register file
module clk_div_trans_mon #(
  parameter int NDIR     = 3,
  parameter int NUM_CNTR = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enb,
  output logic            clk10,
  output logic            clk20,
  output logic            clk40,
  input  logic [NDIR-1:0] dir,
  input  logic            le,
  input  logic [31:0]     dato_in,
  output logic [31:0]     dato_out
);
  logic [2:0]  c10_q, c10_d;
  logic [3:0]  c20_q, c20_d;
  logic [4:0]  c40_q, c40_d;
  logic        clk10_q, clk10_d, clk20_q, clk20_d, clk40_q, clk40_d;
  logic        t10, t20, t40;
  logic [NUM_CNTR:0] inc;
  logic [31:0] mem_q [NUM_CNTR+1];
  logic [31:0] mem_d [NUM_CNTR+1];
  // divider next state: each counter wraps at half its ratio and toggles its output there
  always_comb begin
    t10 = enb && c10_q == 3'd4;
    t20 = enb && c20_q == 4'd9;
    t40 = enb && c40_q == 5'd19;
    c10_d = !enb ? c10_q : t10 ? 3'd0 : c10_q + 3'd1;
    c20_d = !enb ? c20_q : t20 ? 4'd0 : c20_q + 4'd1;
    c40_d = !enb ? c40_q : t40 ? 5'd0 : c40_q + 5'd1;
    clk10_d = clk10_q ^ t10;
    clk20_d = clk20_q ^ t20;
    clk40_d = clk40_q ^ t40;
  end
  // counter memory next state: auto-increment on toggles, host write overrides
  always_comb begin
    inc = '0;
    inc[2:0] = {t40, t20, t10};
    for (int i = 0; i <= NUM_CNTR; i++) begin
      mem_d[i] = inc[i] ? mem_q[i] + 32'd1 : mem_q[i];
      if (!le && int'(dir) == i) mem_d[i] = dato_in;
    end
  end
  // state registers, cleared asynchronously so outputs drop without a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c10_q <= '0;
      c20_q <= '0;
      c40_q <= '0;
      clk10_q <= 1'b0;
      clk20_q <= 1'b0;
      clk40_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      c10_q <= c10_d;
      c20_q <= c20_d;
      c40_q <= c40_d;
      clk10_q <= clk10_d;
      clk20_q <= clk20_d;
      clk40_q <= clk40_d;
      mem_q <= mem_d;
    end
  end
  assign clk10 = clk10_q;
  assign clk20 = clk20_q;
  assign clk40 = clk40_q;
  assign dato_out = (le && int'(dir) <= NUM_CNTR) ? mem_q[dir] : 32'd0;
endmodule

// File: tb/tb_clk_div_trans_mon.sv
// tb_clk_div_trans_mon: directed bench with a cycle-count model of the dividers and counter memory
module tb_clk_div_trans_mon;
  logic        clk = 1'b0, rst = 1'b1, enb = 1'b0, le = 1'b1;
  logic [2:0]  dir = '0;
  logic [31:0] dato_in = '0;
  logic        clk10, clk20, clk40;
  logic [31:0] dato_out;
  int          checks = 0, failures = 0;
  int          n = 0;
  logic [31:0] m [8];

  clk_div_trans_mon dut (
    .clk(clk), .rst(rst), .enb(enb), .clk10(clk10), .clk20(clk20), .clk40(clk40),
    .dir(dir), .le(le), .dato_in(dato_in), .dato_out(dato_out)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8; i++) m[i] = '0;

  // n = enabled clk edges since reset; divided clocks follow from n, counters from toggle counts
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n <= 0;
      for (int i = 0; i < 8; i++) m[i] <= '0;
    end else begin
      if (enb) begin
        n <= n + 1;
        if ((n + 1) % 5 == 0) m[0] <= m[0] + 32'd1;
        if ((n + 1) % 10 == 0) m[1] <= m[1] + 32'd1;
        if ((n + 1) % 20 == 0) m[2] <= m[2] + 32'd1;
      end
      if (!le) m[dir] <= dato_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("clk10", {31'd0, clk10}, 32'((n / 5) % 2));
    chk("clk20", {31'd0, clk20}, 32'((n / 10) % 2));
    chk("clk40", {31'd0, clk40}, 32'((n / 20) % 2));
    chk("dato_out", dato_out, le ? m[dir] : 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    le = 1'b1;
    dir = a;
    #1;
    chk(name, dato_out, exp);
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    enb = 1'b1;
    repeat (4) step();
    chk("clk10_e4", {31'd0, clk10}, 32'd0);
    step();
    chk("clk10_e5", {31'd0, clk10}, 32'd1);
    repeat (4) step();
    chk("clk20_e9", {31'd0, clk20}, 32'd0);
    step();
    chk("clk20_e10", {31'd0, clk20}, 32'd1);
    repeat (9) step();
    chk("clk40_e19", {31'd0, clk40}, 32'd0);
    step();
    chk("clk40_e20", {31'd0, clk40}, 32'd1);
    repeat (180) step();
    rd(3'd0, 32'd40, "cnt10_200");
    rd(3'd1, 32'd20, "cnt20_200");
    rd(3'd2, 32'd10, "cnt40_200");
    repeat (57) step();
    enb = 1'b0;
    repeat (30) step();
    enb = 1'b1;
    repeat (40) step();
    enb = 1'b0;
    le = 1'b0;
    dato_in = '0;
    for (int i = 0; i < 8; i++) begin
      dir = 3'(i);
      step();
    end
    for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "clear_rd");
    le = 1'b0;
    dir = 3'd5;
    dato_in = 32'hDEADBEEF;
    step();
    le = 1'b1;
    enb = 1'b1;
    repeat (50) step();
    rd(3'd5, 32'hDEADBEEF, "plain_rd5");
    dir = 3'd0;
    for (int k = 0; k < 10 && n % 5 != 3; k++) step();
    le = 1'b0;
    dato_in = 32'hFFFFFFFF;
    step();
    le = 1'b1;
    step();
    rd(3'd0, 32'd0, "wrap");
    for (int k = 0; k < 10 && n % 5 != 4; k++) step();
    le = 1'b0;
    dato_in = 32'h1234;
    step();
    rd(3'd0, 32'h1234, "write_wins");
    for (int k = 0; k < 45 && !clk20; k++) step();
    chk("clk20_high", {31'd0, clk20}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst_clk10", {31'd0, clk10}, 32'd0);
    chk("rst_clk20", {31'd0, clk20}, 32'd0);
    chk("rst_clk40", {31'd0, clk40}, 32'd0);
    for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "rst_rd");
    dir = 3'd0;
    step();
    rst = 1'b1;
    repeat (4) step();
    chk("rel_clk10_e4", {31'd0, clk10}, 32'd0);
    step();
    chk("rel_clk10_e5", {31'd0, clk10}, 32'd1);
    repeat (20) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clk_div_trans_mon.md
Name: clk_div_trans_mon

Overview:
- Clock-divider and power-estimation monitor for the PCIe serial interface.
- From the serial bit clock it derives the symbol-rate clocks: clk10 for 8-bit/10-bit symbols, clk20 for 16-bit words and clk40 for 32-bit words.
- Inside is a small transition-counter memory (a register file). It counts toggles of each derived clock and provides host-writable/readable slots for other power counters.
- Sits beside the transmitter/receiver. One instance per clock domain (Tx, Rx).

Parameters:
- NDIR, 3, address width of the counter memory.
- NUM_CNTR, 7, highest valid address; memory holds NUM_CNTR+1 32-bit entries.

Ports:
- clk, input, 1: serial bit clock; all state on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- enb, input, 1: divider enable; 0 freezes divider state.
- clk10, output, 1: clk divided by 10, 50% duty.
- clk20, output, 1: clk divided by 20, 50% duty.
- clk40, output, 1: clk divided by 40, 50% duty.
- dir, input, NDIR: counter-memory address.
- le, input, 1: 1 = read, 0 = write.
- dato_in, input, 32: write data.
- dato_out, output, 32: read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - Divider counters and clk10/clk20/clk40 = 0.
  - All memory entries = 0.
  - dato_out follows the read rule below.
- Divider, per output with ratio N (10, 20, 40):
  - Internal counter c with range 0..N/2-1.
  - On posedge clk with enb=1: if c==N/2-1, then c<=0 and output toggles; else c<=c+1.
  - enb=0: c and output hold their values.
  - All three dividers share enb and rst, so their phases stay aligned: every clk40 edge coincides with a clk20 edge and a clk10 edge.
  - After rst deasserts with enb=1:
    - clk10 first rises at the 5th posedge of clk, clk20 at the 10th, clk40 at the 20th.
    - Period in clk cycles = 10/20/40, high for 5/10/20 cycles.
- Transition counters:
  - Entries 0, 1, 2 count toggles (both edges) of clk10, clk20, clk40 respectively.
  - Increment occurs at the clk edge on which the divider output is updated.
  - 32-bit wrap-around from 0xFFFFFFFF to 0.
- Host write:
  - le=0: on posedge clk, mem[dir] <= dato_in.
  - A write takes priority over a simultaneous auto-increment of the same entry.
  - Writes to dir > NUM_CNTR are ignored.
- Host read:
  - Combinational. When le=1: dato_out = mem[dir], or 0 if dir > NUM_CNTR.
  - When le=0: dato_out = 0.
- Entries 3..NUM_CNTR are plain storage and are never auto-incremented.
- Reset mid-operation: the divider restarts from phase 0, and counters clear regardless of enb/le.
- rst deassertion must not itself produce a toggle; the first toggle occurs no earlier than the counts above.

Test Plan:
- Reset then enb=1, le=1, dir=0; run 100 clk cycles -> clk10 rises at clk edge 5 with period 10; clk20 rises at edge 10 with period 20; clk40 rises at edge 20 with period 40; duty 50% on all three.
- After 200 enabled clk cycles read dir=0,1,2 -> dato_out = 40, 20, 10.
- Run 57 cycles, drop enb for 30 cycles, re-enable -> outputs and dato_out for dir 0..2 are unchanged throughout the frozen interval; resumed phase is continuous.
- le=0, write dir=0..7 with 0, then le=1 and read all -> every entry reads 0. Write 0xDEADBEEF to dir=5 -> reads 0xDEADBEEF and is never incremented.
- Write 0xFFFFFFFF to dir=0 one cycle before a clk10 toggle, then read after the toggle -> value 0 (wrap). Write dir=0 with 0x1234 on the exact toggle cycle -> value 0x1234 (write wins).
- Assert rst mid-run while clk20=1 -> clk10/clk20/clk40 go 0 immediately without waiting for a clock edge, all entries read 0, and after release clk10 rises again at the 5th posedge.
